// File: rtl/qupls4_pkg.sv
// Shared types for the QuPLS4 data-port execution controller.
// Holds the port FSM states, exception codes and the per-beat request bundle.
package qupls4_pkg;

    localparam int MP_PADR_W = 32;
    localparam int MP_DATA_W = 128;
    localparam int MP_SEL_W  = MP_DATA_W / 8;

    typedef enum logic [2:0] {
        MPS_IDLE  = 3'd0,
        MPS_REQ0  = 3'd1,
        MPS_RSP0  = 3'd2,
        MPS_REQ1  = 3'd3,
        MPS_RSP1  = 3'd4,
        MPS_WB    = 3'd5,
        MPS_DRAIN = 3'd6
    } mem_port_state_t;

    localparam logic [1:0] MPX_NONE = 2'b00;
    localparam logic [1:0] MPX_BERR = 2'b01;
    localparam logic [1:0] MPX_TMO  = 2'b10;

    typedef struct packed {
        logic [MP_PADR_W-1:0] adr;
        logic [MP_SEL_W-1:0]  sel;
        logic [MP_DATA_W-1:0] dat;
        logic                 we;
    } beat_req_t;

endpackage

// File: rtl/qupls4_mem_align.sv
// Beat split detection, byte-lane alignment of store data and enables,
// and right-justified merge of the two load beats.
module qupls4_mem_align
    import qupls4_pkg::*;
#(
    parameter int PADR_W = MP_PADR_W,
    parameter int DATA_W = MP_DATA_W
) (
    input  logic [PADR_W-1:0] padr_i,
    input  logic [2:0]        size_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] st_dat_i,
    input  logic [DATA_W-1:0] rd0_i,
    input  logic [DATA_W-1:0] rd1_i,
    output logic              split_o,
    output beat_req_t         beat0_o,
    output beat_req_t         beat1_o,
    output logic [DATA_W-1:0] ld_dat_o
);

    localparam int BB = DATA_W / 8;
    localparam int OW = $clog2(BB);

    logic [OW-1:0]       off;
    logic [OW:0]         nbytes;
    logic [2*BB-1:0]     msk_raw;
    logic [2*BB-1:0]     msk;
    logic [DATA_W-1:0]   lmask;
    logic [2*DATA_W-1:0] sdat;
    logic [2*DATA_W-1:0] rdat;
    logic [PADR_W-1:0]   base;

    always_comb begin
        off     = padr_i[OW-1:0];
        nbytes  = (OW+1)'(1) << size_i;
        split_o = ({1'b0, off} + nbytes) > (OW+1)'(BB);
        msk_raw = '0;
        lmask   = '0;
        for (int i = 0; i < BB; i++) begin
            if (i < int'(nbytes)) begin
                msk_raw[i]      = 1'b1;
                lmask[i*8 +: 8] = 8'hFF;
            end
        end
        msk  = msk_raw << off;
        // Two-beat wide window: low half feeds beat 0, high half beat 1.
        sdat = {{DATA_W{1'b0}}, st_dat_i} << {off, 3'b000};
        rdat = {rd1_i, rd0_i} >> {off, 3'b000};
        ld_dat_o = rdat[DATA_W-1:0] & lmask;
        base = {padr_i[PADR_W-1:OW], {OW{1'b0}}};

        beat0_o.adr = base;
        beat0_o.sel = msk[BB-1:0];
        beat0_o.dat = sdat[DATA_W-1:0];
        beat0_o.we  = we_i;
        beat1_o.adr = base + PADR_W'(BB);
        beat1_o.sel = msk[2*BB-1:BB];
        beat1_o.dat = sdat[2*DATA_W-1:DATA_W];
        beat1_o.we  = we_i;
    end

endmodule

// File: rtl/qupls4_mem_port_ctrl.sv
// Per-data-port controller: takes one issued LSQ entry, runs one or two
// cache beats with timeout and stomp handling, and reports writeback.
module qupls4_mem_port_ctrl
    import qupls4_pkg::*;
#(
    parameter int PADR_W      = MP_PADR_W,
    parameter int DATA_W      = MP_DATA_W,
    parameter int LSQ_NDX_W   = 5,
    parameter int ROB_ENTRIES = 16,
    parameter int TIMEOUT     = 255,
    localparam int ROB_NDX_W  = $clog2(ROB_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_v,
    input  logic [LSQ_NDX_W-1:0]   issue_ndx,
    input  logic [ROB_NDX_W-1:0]   issue_rndx,
    input  logic                   issue_load,
    input  logic                   issue_store,
    input  logic [PADR_W-1:0]      issue_padr,
    input  logic [2:0]             issue_size,
    input  logic [DATA_W-1:0]      issue_data,
    input  logic [ROB_ENTRIES-1:0] stomp,
    output logic                   busy,
    output logic                   dc_req_v,
    input  logic                   dc_req_rdy,
    output logic                   dc_req_we,
    output logic [PADR_W-1:0]      dc_req_adr,
    output logic [DATA_W/8-1:0]    dc_req_sel,
    output logic [DATA_W-1:0]      dc_req_dat,
    input  logic                   dc_resp_v,
    input  logic [DATA_W-1:0]      dc_resp_dat,
    input  logic                   dc_resp_err,
    output logic                   wb_v,
    output logic [ROB_NDX_W-1:0]   wb_rndx,
    output logic [LSQ_NDX_W-1:0]   wb_lsq_ndx,
    output logic [DATA_W-1:0]      wb_data,
    output logic [1:0]             wb_exc
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    mem_port_state_t        state_q, state_d;
    logic [LSQ_NDX_W-1:0]   ndx_q, ndx_d;
    logic [ROB_NDX_W-1:0]   rndx_q, rndx_d;
    logic                   load_q, load_d;
    logic                   store_q, store_d;
    logic [PADR_W-1:0]      padr_q, padr_d;
    logic [2:0]             size_q, size_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [DATA_W-1:0]      beat0_q, beat0_d;
    logic [DATA_W-1:0]      beat1_q, beat1_d;
    logic [1:0]             exc_q, exc_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;

    logic                   split;
    beat_req_t              bq0, bq1, cur;
    logic [DATA_W-1:0]      ld_dat;
    logic                   stomped;
    logic                   tmo_hit;
    logic                   req_v;

    qupls4_mem_align #(
        .PADR_W (PADR_W),
        .DATA_W (DATA_W)
    ) u_align (
        .padr_i   (padr_q),
        .size_i   (size_q),
        .we_i     (store_q),
        .st_dat_i (data_q),
        .rd0_i    (beat0_q),
        .rd1_i    (beat1_q),
        .split_o  (split),
        .beat0_o  (bq0),
        .beat1_o  (bq1),
        .ld_dat_o (ld_dat)
    );

    assign stomped = stomp[rndx_q];
    // Counter starts at 1 on acceptance, so the acceptance cycle is counted.
    assign tmo_hit = tmo_q >= TMO_W'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        ndx_d   = ndx_q;
        rndx_d  = rndx_q;
        load_d  = load_q;
        store_d = store_q;
        padr_d  = padr_q;
        size_d  = size_q;
        data_d  = data_q;
        beat0_d = beat0_q;
        beat1_d = beat1_q;
        exc_d   = exc_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            MPS_IDLE: begin
                if (issue_v) begin
                    state_d = MPS_REQ0;
                    ndx_d   = issue_ndx;
                    rndx_d  = issue_rndx;
                    load_d  = issue_load;
                    store_d = issue_store;
                    padr_d  = issue_padr;
                    size_d  = issue_size;
                    data_d  = issue_data;
                    beat0_d = '0;
                    beat1_d = '0;
                    exc_d   = MPX_NONE;
                    tmo_d   = '0;
                end
            end
            MPS_REQ0, MPS_REQ1: begin
                if (dc_req_rdy) begin
                    tmo_d = TMO_W'(1);
                    if (stomped)
                        state_d = MPS_DRAIN;
                    else if (state_q == MPS_REQ0)
                        state_d = MPS_RSP0;
                    else
                        state_d = MPS_RSP1;
                end else if (stomped) begin
                    state_d = MPS_IDLE;
                end
            end
            MPS_RSP0, MPS_RSP1: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (dc_resp_v) begin
                    if (state_q == MPS_RSP0)
                        beat0_d = dc_resp_dat;
                    else
                        beat1_d = dc_resp_dat;
                    if (stomped) begin
                        state_d = MPS_IDLE;
                    end else if (dc_resp_err) begin
                        exc_d   = MPX_BERR;
                        state_d = MPS_WB;
                    end else if (state_q == MPS_RSP0 && split) begin
                        state_d = MPS_REQ1;
                    end else begin
                        state_d = MPS_WB;
                    end
                end else if (tmo_hit) begin
                    exc_d   = MPX_TMO;
                    state_d = stomped ? MPS_IDLE : MPS_WB;
                end else if (stomped) begin
                    state_d = MPS_DRAIN;
                end
            end
            MPS_DRAIN: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (dc_resp_v || tmo_hit)
                    state_d = MPS_IDLE;
            end
            MPS_WB: begin
                state_d = MPS_IDLE;
            end
            default: begin
                state_d = MPS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MPS_IDLE;
            ndx_q   <= '0;
            rndx_q  <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            padr_q  <= '0;
            size_q  <= '0;
            data_q  <= '0;
            beat0_q <= '0;
            beat1_q <= '0;
            exc_q   <= MPX_NONE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ndx_q   <= ndx_d;
            rndx_q  <= rndx_d;
            load_q  <= load_d;
            store_q <= store_d;
            padr_q  <= padr_d;
            size_q  <= size_d;
            data_q  <= data_d;
            beat0_q <= beat0_d;
            beat1_q <= beat1_d;
            exc_q   <= exc_d;
            tmo_q   <= tmo_d;
        end
    end

    assign req_v = (state_q == MPS_REQ0) || (state_q == MPS_REQ1);
    assign cur   = (state_q == MPS_REQ1) ? bq1 : bq0;

    assign busy       = state_q != MPS_IDLE;
    assign dc_req_v   = req_v;
    assign dc_req_we  = req_v & cur.we;
    assign dc_req_adr = req_v ? cur.adr : '0;
    assign dc_req_sel = req_v ? cur.sel : '0;
    assign dc_req_dat = req_v ? cur.dat : '0;

    assign wb_v       = state_q == MPS_WB;
    assign wb_rndx    = wb_v ? rndx_q : '0;
    assign wb_lsq_ndx = wb_v ? ndx_q : '0;
    assign wb_data    = (wb_v && load_q) ? ld_dat : '0;
    assign wb_exc     = wb_v ? exc_q : MPX_NONE;

endmodule
